// File: rtl/nios2_debug_pkg.sv
// Shared definitions for the Nios II debug OCI memory controller.
//   - JDO field positions used to decode the JTAG payload
//   - status register bit indices and register offsets
//   - JTAG access FSM state encoding
//   - packed status struct and a helper that formats it for CPU readback
package nios2_debug_pkg;

  localparam int JDO_W         = 38;
  localparam int JDO_ADDR_LSB  = 17;  // word address field for take_action_ocimem_a
  localparam int JDO_RDREQ     = 34;  // take_action_ocimem_a: read after address load
  localparam int JDO_CLR       = 25;  // take_action_ocimem_a: clear monitor flags
  localparam int JDO_WDATA_LSB = 3;   // take_action_ocimem_b: jdo[34:3] write data

  localparam int ST_READY   = 0;
  localparam int ST_ERROR   = 1;
  localparam int ST_OVERRUN = 2;

  localparam int REG_STATUS  = 0;
  localparam int REG_MONAREG = 1;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_J_RD  = 2'd1,
    S_J_CAP = 2'd2,
    S_J_WR  = 2'd3
  } jtag_state_e;

  // Field order makes the packed value line up with the ST_* indices.
  typedef struct packed {
    logic overrun;
    logic error;
    logic ready;
  } mon_status_t;

  function automatic logic [31:0] status_word(input mon_status_t s);
    return 32'(s);
  endfunction

endpackage

// File: rtl/nios2_debug_ocimem_ram.sv
// Single-port, byte-writable synchronous RAM for the debug monitor.
//   clk   : clock
//   en    : access enable
//   we    : per-byte write enables (0 = read access)
//   addr  : word address
//   wdata : write data
//   q     : read data, valid the cycle after a read access; holds otherwise
// Contents are never reset. With INIT_ZERO the array starts out all zero.
module nios2_debug_ocimem_ram #(
  parameter int ADDR_W    = 8,
  parameter bit INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              en,
  input  logic [3:0]        we,
  input  logic [ADDR_W-1:0] addr,
  input  logic [31:0]       wdata,
  output logic [31:0]       q
);

  localparam int DEPTH = 1 << ADDR_W;

  generate
    if (INIT_ZERO) begin : g_zero
      logic [31:0] mem [DEPTH] = '{default: '0};

      always_ff @(posedge clk) begin
        if (en) begin
          for (int b = 0; b < 4; b++)
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          if (we == 4'b0000) q <= mem[addr];
        end
      end
    end else begin : g_raw
      logic [31:0] mem [DEPTH];

      always_ff @(posedge clk) begin
        if (en) begin
          for (int b = 0; b < 4; b++)
            if (we[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
          if (we == 4'b0000) q <= mem[addr];
        end
      end
    end
  endgenerate

endmodule

// File: rtl/nios2_debug_ocimem_ctrl.sv
// Debug OCI memory controller. Executes JTAG debug-slave commands against a
// private monitor RAM and shares that RAM with the CPU's Avalon-MM slave.
//   clk, reset_n                 : clock, async active-low reset
//   jdo                          : JTAG payload, stable while a take_* pulse is high
//   take_action_ocimem_a         : load MonAReg, optionally clear flags / read
//   take_no_action_ocimem_a      : streaming read at MonAReg
//   take_action_ocimem_b         : write jdo[34:3] at MonAReg
//   avs_*                        : CPU slave; address MSB selects register region
//   MonDReg                      : JTAG-visible data register
//   monitor_ready, monitor_error : monitor handshake flags
module nios2_debug_ocimem_ctrl
  import nios2_debug_pkg::*;
#(
  parameter int ADDR_W        = 8,
  parameter bit RAM_INIT_ZERO = 1'b1
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic [JDO_W-1:0]  jdo,
  input  logic              take_action_ocimem_a,
  input  logic              take_no_action_ocimem_a,
  input  logic              take_action_ocimem_b,
  input  logic [ADDR_W:0]   avs_address,
  input  logic              avs_read,
  input  logic              avs_write,
  input  logic [31:0]       avs_writedata,
  input  logic [3:0]        avs_byteenable,
  output logic [31:0]       avs_readdata,
  output logic              avs_waitrequest,
  output logic [31:0]       MonDReg,
  output logic              monitor_ready,
  output logic              monitor_error
);

  jtag_state_e       state_q, state_d;
  logic [ADDR_W-1:0] mon_a_q;
  logic [31:0]       mon_d_q;
  mon_status_t       stat_q;
  logic              rd_pend_q, rd_is_reg_q;
  logic [31:0]       reg_rdata_q;

  logic              idle, any_take, jtag_start, jtag_own;
  logic              cpu_is_reg, cpu_wr, cpu_rd, stat_wr;
  logic [ADDR_W-1:0] cpu_off;
  logic [31:0]       reg_rdata;

  logic              ram_en;
  logic [3:0]        ram_we;
  logic [ADDR_W-1:0] ram_addr;
  logic [31:0]       ram_wdata, ram_q;
  logic              cap_en, inc_a;

  // Only the address/flag fields and jdo[34:3] carry meaning here.
  logic unused_jdo;
  assign unused_jdo = ^{jdo[JDO_W-1:JDO_RDREQ+1], jdo[JDO_WDATA_LSB-1:0]};

  assign idle     = (state_q == S_IDLE);
  assign any_take = take_action_ocimem_a | take_no_action_ocimem_a | take_action_ocimem_b;

  // A pulse leaves IDLE unless it is an address-only load; pulse 'a' masks
  // the lower-priority pulses even when it stays in IDLE.
  assign jtag_start = idle & (take_action_ocimem_a ? jdo[JDO_RDREQ]
                                                   : (take_no_action_ocimem_a | take_action_ocimem_b));
  assign jtag_own   = ~idle | jtag_start;

  // CPU accesses (RAM and registers alike) are held off while JTAG owns the
  // RAM, so a register read never races a JTAG update of the same state.
  assign cpu_is_reg = avs_address[ADDR_W];
  assign cpu_off    = avs_address[ADDR_W-1:0];
  assign cpu_wr     = avs_write & ~jtag_own;
  assign cpu_rd     = avs_read & ~avs_write & ~rd_pend_q & ~jtag_own;
  assign stat_wr    = cpu_wr & cpu_is_reg & (cpu_off == ADDR_W'(REG_STATUS));

  always_comb begin
    reg_rdata = '0;
    if (cpu_off == ADDR_W'(REG_STATUS))       reg_rdata = status_word(stat_q);
    else if (cpu_off == ADDR_W'(REG_MONAREG)) reg_rdata = 32'(mon_a_q);
  end

  // Writes never stall except on JTAG ownership; a read stalls until its
  // data phase, which is the cycle after issue.
  assign avs_waitrequest = avs_write ? jtag_own : (avs_read & ~rd_pend_q);
  assign avs_readdata    = rd_pend_q ? (rd_is_reg_q ? reg_rdata_q : ram_q) : '0;

  assign MonDReg       = mon_d_q;
  assign monitor_ready = stat_q.ready;
  assign monitor_error = stat_q.error;

  // ---------------- FSM: state register ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // ---------------- FSM: next state ----------------
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE: begin
        if (take_action_ocimem_a)         state_d = jdo[JDO_RDREQ] ? S_J_RD : S_IDLE;
        else if (take_no_action_ocimem_a) state_d = S_J_RD;
        else if (take_action_ocimem_b)    state_d = S_J_WR;
      end
      S_J_RD:  state_d = S_J_CAP;
      S_J_CAP: state_d = S_IDLE;
      S_J_WR:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // ---------------- FSM: outputs (RAM port mux, register strobes) ----------------
  always_comb begin
    ram_en    = 1'b0;
    ram_we    = 4'b0000;
    ram_addr  = mon_a_q;
    ram_wdata = mon_d_q;
    cap_en    = 1'b0;
    inc_a     = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        ram_addr  = cpu_off;
        ram_wdata = avs_writedata;
        if (cpu_wr & ~cpu_is_reg) begin
          ram_en = 1'b1;
          ram_we = avs_byteenable;
        end else if (cpu_rd & ~cpu_is_reg) begin
          ram_en = 1'b1;
        end
      end
      S_J_RD:  ram_en = 1'b1;
      S_J_CAP: begin
        cap_en = 1'b1;
        inc_a  = 1'b1;
      end
      S_J_WR: begin
        ram_en = 1'b1;
        ram_we = 4'b1111;
        inc_a  = 1'b1;
      end
      default: ;
    endcase
  end

  // ---------------- JTAG-visible registers ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      mon_a_q <= '0;
      mon_d_q <= '0;
    end else begin
      if (idle & take_action_ocimem_a)
        mon_a_q <= jdo[JDO_ADDR_LSB +: ADDR_W];
      else if (inc_a)
        mon_a_q <= mon_a_q + ADDR_W'(1);

      if (idle & ~take_action_ocimem_a & ~take_no_action_ocimem_a & take_action_ocimem_b)
        mon_d_q <= jdo[JDO_WDATA_LSB +: 32];
      else if (cap_en)
        mon_d_q <= ram_q;
    end
  end

  // ---------------- status flags ----------------
  // JTAG flag clear beats a same-cycle CPU write; a new overrun beats W1C.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_q <= '0;
    end else begin
      if (idle & take_action_ocimem_a & jdo[JDO_CLR]) begin
        stat_q.ready <= 1'b0;
        stat_q.error <= 1'b0;
      end else if (stat_wr) begin
        stat_q.ready <= avs_writedata[ST_READY];
        stat_q.error <= avs_writedata[ST_ERROR];
      end

      if (~idle & any_take)
        stat_q.overrun <= 1'b1;
      else if (stat_wr & avs_writedata[ST_OVERRUN])
        stat_q.overrun <= 1'b0;
    end
  end

  // ---------------- CPU read pipeline ----------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      rd_pend_q   <= 1'b0;
      rd_is_reg_q <= 1'b0;
      reg_rdata_q <= '0;
    end else begin
      rd_pend_q   <= cpu_rd;
      rd_is_reg_q <= cpu_rd & cpu_is_reg;
      if (cpu_rd & cpu_is_reg) reg_rdata_q <= reg_rdata;
    end
  end

  nios2_debug_ocimem_ram #(
    .ADDR_W    (ADDR_W),
    .INIT_ZERO (RAM_INIT_ZERO)
  ) u_ram (
    .clk   (clk),
    .en    (ram_en),
    .we    (ram_we),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .q     (ram_q)
  );

endmodule

// File: tb/tb_nios2_debug_ocimem_ctrl.sv
// Directed self-checking bench for nios2_debug_ocimem_ctrl.
module tb_nios2_debug_ocimem_ctrl;

  localparam int ADDR_W = 8;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic [37:0]       jdo = '0;
  logic              take_action_ocimem_a = 1'b0;
  logic              take_no_action_ocimem_a = 1'b0;
  logic              take_action_ocimem_b = 1'b0;
  logic [ADDR_W:0]   avs_address = '0;
  logic              avs_read = 1'b0;
  logic              avs_write = 1'b0;
  logic [31:0]       avs_writedata = '0;
  logic [3:0]        avs_byteenable = 4'hF;
  logic [31:0]       avs_readdata;
  logic              avs_waitrequest;
  logic [31:0]       MonDReg;
  logic              monitor_ready;
  logic              monitor_error;

  int n_checks = 0;
  int n_fail   = 0;

  nios2_debug_ocimem_ctrl #(.ADDR_W(ADDR_W), .RAM_INIT_ZERO(1'b1)) dut (
    .clk                     (clk),
    .reset_n                 (reset_n),
    .jdo                     (jdo),
    .take_action_ocimem_a    (take_action_ocimem_a),
    .take_no_action_ocimem_a (take_no_action_ocimem_a),
    .take_action_ocimem_b    (take_action_ocimem_b),
    .avs_address             (avs_address),
    .avs_read                (avs_read),
    .avs_write               (avs_write),
    .avs_writedata           (avs_writedata),
    .avs_byteenable          (avs_byteenable),
    .avs_readdata            (avs_readdata),
    .avs_waitrequest         (avs_waitrequest),
    .MonDReg                 (MonDReg),
    .monitor_ready           (monitor_ready),
    .monitor_error           (monitor_error)
  );

  always #5 clk = ~clk;

  localparam logic [8:0] A_STATUS = 9'h100;
  localparam logic [8:0] A_MONA   = 9'h101;

  function automatic logic [37:0] jdo_a(input logic [7:0] addr, input logic rdreq, input logic clr);
    logic [37:0] j;
    j = '0;
    j[24:17] = addr;
    j[34] = rdreq;
    j[25] = clr;
    return j;
  endfunction

  function automatic logic [37:0] jdo_b(input logic [31:0] data);
    logic [37:0] j;
    j = '0;
    j[34:3] = data;
    return j;
  endfunction

  // Tasks start and end 1 time unit after a rising edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic jtag_pulse(input logic a, input logic na, input logic b, input logic [37:0] j);
    jdo = j;
    take_action_ocimem_a = a;
    take_no_action_ocimem_a = na;
    take_action_ocimem_b = b;
    step();
    take_action_ocimem_a = 1'b0;
    take_no_action_ocimem_a = 1'b0;
    take_action_ocimem_b = 1'b0;
  endtask

  task automatic cpu_write(input logic [8:0] a, input logic [31:0] d, input logic [3:0] be);
    int n;
    logic stall;
    n = 0;
    avs_address = a; avs_writedata = d; avs_byteenable = be; avs_write = 1'b1;
    do begin
      #1 stall = avs_waitrequest;
      step();
      n++;
    end while (stall && n < 16);
    avs_write = 1'b0;
    if (stall) begin
      n_checks++; n_fail++;
      $display("FAIL cpu_write_timeout: addr=%h still stalled after %0d cycles", a, n);
    end
  endtask

  task automatic cpu_read(input logic [8:0] a, output logic [31:0] data, output int cyc);
    logic got;
    got = 1'b0; cyc = 0; data = '0;
    avs_address = a; avs_read = 1'b1;
    while (!got && cyc < 16) begin
      #1;
      if (!avs_waitrequest) begin
        data = avs_readdata;
        got = 1'b1;
      end
      step();
      cyc++;
    end
    avs_read = 1'b0;
    if (!got) begin
      n_checks++; n_fail++;
      $display("FAIL cpu_read_timeout: addr=%h still stalled after %0d cycles", a, cyc);
    end
  endtask

  // ------------------------------------------------------------------
  task automatic test_reset();
    logic [31:0] d;
    int c;
    #2;
    n_checks++; if (MonDReg !== 32'h0) begin n_fail++; $display("FAIL rst_mondreg: got %h want 0", MonDReg); end
    n_checks++; if (monitor_ready !== 1'b0) begin n_fail++; $display("FAIL rst_ready: got %b want 0", monitor_ready); end
    n_checks++; if (monitor_error !== 1'b0) begin n_fail++; $display("FAIL rst_error: got %b want 0", monitor_error); end
    n_checks++; if (avs_readdata !== 32'h0) begin n_fail++; $display("FAIL rst_readdata: got %h want 0", avs_readdata); end
    n_checks++; if (avs_waitrequest !== 1'b0) begin n_fail++; $display("FAIL rst_waitreq: got %b want 0", avs_waitrequest); end
    repeat (2) step();
    reset_n = 1'b1;
    step();

    // Build up non-zero state, then reset while the FSM sits in J_RD.
    jtag_pulse(1, 0, 0, jdo_a(8'h03, 1'b0, 1'b0));
    jtag_pulse(0, 0, 1, jdo_b(32'h55AA_55AA));
    step();
    cpu_write(A_STATUS, 32'h3, 4'hF);
    jtag_pulse(1, 0, 0, jdo_a(8'h03, 1'b1, 1'b0));   // now in J_RD
    reset_n = 1'b0;
    #1;
    n_checks++; if (MonDReg !== 32'h0) begin n_fail++; $display("FAIL rst_mid_mondreg: got %h want 0", MonDReg); end
    n_checks++; if (monitor_ready !== 1'b0 || monitor_error !== 1'b0) begin
      n_fail++; $display("FAIL rst_mid_flags: got %b%b want 00", monitor_error, monitor_ready); end
    step();
    step();
    n_checks++; if (MonDReg !== 32'h0) begin n_fail++; $display("FAIL rst_no_capture: got %h want 0", MonDReg); end
    reset_n = 1'b1;
    step();
    cpu_read(A_STATUS, d, c);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_status_read: got %h want 0", d); end
    cpu_read(A_MONA, d, c);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL rst_monareg_read: got %h want 0", d); end
    cpu_read(9'h003, d, c);
    n_checks++; if (d !== 32'h55AA_55AA) begin n_fail++; $display("FAIL rst_ram_kept: got %h want 55aa55aa", d); end
  endtask

  // ------------------------------------------------------------------
  task automatic test_jtag_write_burst();
    logic [31:0] d;
    logic [31:0] exp;
    int c;
    jtag_pulse(1, 0, 0, jdo_a(8'h10, 1'b0, 1'b0));
    repeat (9) step();
    for (int i = 1; i <= 3; i++) begin
      exp = 32'hA5A5_0000 | 32'(i);
      jtag_pulse(0, 0, 1, jdo_b(exp));
      n_checks++; if (MonDReg !== exp) begin n_fail++; $display("FAIL burst_mondreg%0d: got %h want %h", i, MonDReg, exp); end
      repeat (9) step();
    end
    for (int i = 0; i < 3; i++) begin
      exp = 32'hA5A5_0001 + 32'(i);
      cpu_read(9'(8'h10 + i), d, c);
      n_checks++; if (d !== exp) begin n_fail++; $display("FAIL burst_ram%0d: got %h want %h", i, d, exp); end
      n_checks++; if (c !== 2) begin n_fail++; $display("FAIL burst_rd_cycles%0d: got %0d want 2", i, c); end
    end
    cpu_read(A_MONA, d, c);
    n_checks++; if (d !== 32'h13) begin n_fail++; $display("FAIL burst_monareg: got %h want 13", d); end
  endtask

  // ------------------------------------------------------------------
  task automatic test_stream_read();
    logic [31:0] d;
    int c;
    cpu_write(9'h0FF, 32'hDEAD_BEEF, 4'hF);
    cpu_write(9'h000, 32'h1234_5678, 4'hF);
    jtag_pulse(1, 0, 0, jdo_a(8'hFF, 1'b1, 1'b0));
    step();
    n_checks++; if (MonDReg !== 32'hA5A5_0003) begin n_fail++; $display("FAIL stream_early: got %h want a5a50003", MonDReg); end
    step();
    n_checks++; if (MonDReg !== 32'hDEAD_BEEF) begin n_fail++; $display("FAIL stream_first: got %h want deadbeef", MonDReg); end
    repeat (3) step();
    jtag_pulse(0, 1, 0, 38'h0);
    repeat (2) step();
    n_checks++; if (MonDReg !== 32'h1234_5678) begin n_fail++; $display("FAIL stream_wrap: got %h want 12345678", MonDReg); end
    cpu_read(A_MONA, d, c);
    n_checks++; if (d !== 32'h1) begin n_fail++; $display("FAIL stream_monareg: got %h want 1", d); end
  endtask

  // ------------------------------------------------------------------
  task automatic test_contention();
    logic [31:0] d;
    logic got;
    int c;
    cpu_write(9'h005, 32'h1122_3344, 4'hF);
    cpu_write(9'h005, 32'hAABB_CCDD, 4'b0101);
    cpu_read(9'h005, d, c);
    n_checks++; if (d !== 32'h11BB_33DD) begin n_fail++; $display("FAIL byteen: got %h want 11bb33dd", d); end
    n_checks++; if (c !== 2) begin n_fail++; $display("FAIL plain_rd_cycles: got %0d want 2", c); end

    jtag_pulse(1, 0, 0, jdo_a(8'h05, 1'b0, 1'b0));
    // CPU read and JTAG write start in the same cycle.
    jdo = jdo_b(32'hCAFE_0005);
    take_action_ocimem_b = 1'b1;
    avs_address = 9'h005;
    avs_read = 1'b1;
    got = 1'b0; c = 0; d = '0;
    while (!got && c < 16) begin
      #1;
      if (!avs_waitrequest) begin d = avs_readdata; got = 1'b1; end
      step();
      take_action_ocimem_b = 1'b0;
      c++;
    end
    avs_read = 1'b0;
    n_checks++; if (!got || c !== 4) begin n_fail++; $display("FAIL contend_cycles: got %0d want 4", c); end
    n_checks++; if (d !== 32'hCAFE_0005) begin n_fail++; $display("FAIL contend_data: got %h want cafe0005", d); end
  endtask

  // ------------------------------------------------------------------
  task automatic test_overrun_priority();
    logic [31:0] d;
    int c;
    jtag_pulse(1, 0, 0, jdo_a(8'h20, 1'b0, 1'b0));
    // Second b lands while the FSM is in J_WR.
    jdo = jdo_b(32'h0BAD_0001);
    take_action_ocimem_b = 1'b1;
    step();
    jdo = jdo_b(32'h0BAD_0002);
    step();
    take_action_ocimem_b = 1'b0;
    step();
    n_checks++; if (MonDReg !== 32'h0BAD_0001) begin n_fail++; $display("FAIL ovr_mondreg: got %h want 0bad0001", MonDReg); end
    cpu_read(9'h020, d, c);
    n_checks++; if (d !== 32'h0BAD_0001) begin n_fail++; $display("FAIL ovr_ram: got %h want 0bad0001", d); end
    cpu_read(A_MONA, d, c);
    n_checks++; if (d !== 32'h21) begin n_fail++; $display("FAIL ovr_monareg: got %h want 21", d); end
    cpu_read(A_STATUS, d, c);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL ovr_status: got %h want 4", d); end

    // a and b together: only the address load happens.
    cpu_write(9'h030, 32'h1357_2468, 4'hF);
    jtag_pulse(1, 0, 1, jdo_a(8'h30, 1'b0, 1'b0));
    repeat (3) step();
    n_checks++; if (MonDReg !== 32'h0BAD_0001) begin n_fail++; $display("FAIL prio_mondreg: got %h want 0bad0001", MonDReg); end
    cpu_read(9'h030, d, c);
    n_checks++; if (d !== 32'h1357_2468) begin n_fail++; $display("FAIL prio_ram: got %h want 13572468", d); end
    cpu_read(A_MONA, d, c);
    n_checks++; if (d !== 32'h30) begin n_fail++; $display("FAIL prio_monareg: got %h want 30", d); end
    cpu_read(A_STATUS, d, c);
    n_checks++; if (d !== 32'h4) begin n_fail++; $display("FAIL prio_status: got %h want 4", d); end
    cpu_write(A_STATUS, 32'h4, 4'hF);
    cpu_read(A_STATUS, d, c);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL ovr_w1c: got %h want 0", d); end
    cpu_read(9'h102, d, c);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL reg_other: got %h want 0", d); end
  endtask

  // ------------------------------------------------------------------
  task automatic test_monitor_flags();
    logic [31:0] d;
    logic wr;
    int c;
    cpu_write(A_STATUS, 32'h3, 4'hF);
    n_checks++; if (monitor_ready !== 1'b1 || monitor_error !== 1'b1) begin
      n_fail++; $display("FAIL flags_set: got err=%b rdy=%b want 1 1", monitor_error, monitor_ready); end
    cpu_read(A_STATUS, d, c);
    n_checks++; if (d !== 32'h3) begin n_fail++; $display("FAIL flags_read: got %h want 3", d); end

    // JTAG clear and CPU status write in the same cycle.
    jdo = jdo_a(8'h40, 1'b0, 1'b1);
    take_action_ocimem_a = 1'b1;
    avs_address = A_STATUS; avs_writedata = 32'h1; avs_write = 1'b1;
    #1 wr = avs_waitrequest;
    step();
    take_action_ocimem_a = 1'b0;
    avs_write = 1'b0;
    n_checks++; if (wr !== 1'b0) begin n_fail++; $display("FAIL clr_waitreq: got %b want 0", wr); end
    n_checks++; if (monitor_ready !== 1'b0 || monitor_error !== 1'b0) begin
      n_fail++; $display("FAIL clr_flags: got err=%b rdy=%b want 0 0", monitor_error, monitor_ready); end
    cpu_read(A_STATUS, d, c);
    n_checks++; if (d !== 32'h0) begin n_fail++; $display("FAIL clr_status_read: got %h want 0", d); end
    cpu_read(A_MONA, d, c);
    n_checks++; if (d !== 32'h40) begin n_fail++; $display("FAIL clr_monareg: got %h want 40", d); end
  endtask

  initial begin
    test_reset();
    test_jtag_write_burst();
    test_stream_read();
    test_contention();
    test_overrun_priority();
    test_monitor_flags();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

endmodule

// File: doc/nios2_debug_ocimem_ctrl.md
Name: nios2_debug_ocimem_ctrl

Overview:
- Consumes the clk-domain debug-slave command pulses (take_action_ocimem_a/b, take_no_action_ocimem_a) and the jdo payload.
- Executes the decoded JTAG accesses against a private debug-monitor RAM.
- Arbitrates that RAM against the CPU's Avalon-MM debug slave port.
- Returns MonDReg, monitor_ready and monitor_error upstream for the next JTAG capture.

Parameters:
- ADDR_W, 8, word-address width of debug RAM (2^ADDR_W x 32 bits).
- RAM_INIT_ZERO, 1, when 1 the RAM array is zero in simulation.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- jdo  in  38  JTAG data payload, stable while any take_* pulse is high
- take_action_ocimem_a  in  1  1-cycle pulse: load address / optional read
- take_no_action_ocimem_a  in  1  1-cycle pulse: streaming read at current address
- take_action_ocimem_b  in  1  1-cycle pulse: write jdo[34:3] at current address
- avs_address  in  ADDR_W+1  CPU word address; MSB=1 selects the register region
- avs_read  in  1  CPU read strobe
- avs_write  in  1  CPU write strobe
- avs_writedata  in  32  CPU write data
- avs_byteenable  in  4  CPU byte lanes (RAM only)
- avs_readdata  out  32  CPU read data
- avs_waitrequest  out  1  CPU stall
- MonDReg  out  32  JTAG-visible data register
- monitor_ready  out  1  monitor handshake flag
- monitor_error  out  1  monitor error flag

Behaviour:
- Reset (async, reset_n=0): MonDReg=0, MonAReg=0, monitor_ready=0, monitor_error=0, jtag_overrun=0, avs_readdata=0, avs_waitrequest=0, FSM=IDLE. RAM contents are not reset.
- RAM: synchronous single port, 1-cycle read latency, byte-writable.
- JTAG FSM states: IDLE, J_RD, J_CAP, J_WR.
- IDLE + take_action_ocimem_a:
  - MonAReg <= jdo[17+ADDR_W-1:17].
  - If jdo[25]=1, monitor_ready <= 0 and monitor_error <= 0.
  - If jdo[34]=1, go to J_RD; else stay in IDLE.
- IDLE + take_no_action_ocimem_a: go to J_RD.
- IDLE + take_action_ocimem_b: MonDReg <= jdo[34:3]; go to J_WR.
- Simultaneous pulses: priority a > no_action_a > b. Lower-priority pulses are dropped.
- J_RD: drive RAM address = MonAReg, read; go to J_CAP.
- J_CAP: MonDReg <= RAM q; MonAReg <= MonAReg+1; go to IDLE.
- J_WR: write MonDReg to MonAReg with all byte lanes; MonAReg <= MonAReg+1; go to IDLE.
- MonAReg increment wraps 2^ADDR_W-1 -> 0.
- Any take_* pulse while FSM != IDLE: ignored, jtag_overrun <= 1 (sticky).
- Arbitration: JTAG owns the RAM whenever FSM != IDLE, or when a JTAG transition out of IDLE happens this cycle. CPU is stalled (avs_waitrequest=1) during that time.
- CPU RAM read: cycle 0 issues the read with waitrequest=1. Cycle 1 presents readdata with waitrequest=0. Total 2 cycles if uncontended.
- CPU RAM write: completes in the cycle accepted, waitrequest=0, byteenable honoured.
- Register region (address MSB=1): reads take 2 cycles like RAM. Writes take 1 cycle.
  - Offset 0 status: bit0 monitor_ready (RW), bit1 monitor_error (RW), bit2 jtag_overrun (RW1C), bits31:3 = 0.
  - Offset 1 MonAReg: read-only, zero-extended.
  - Other offsets: read 0, writes ignored.
- Same-cycle CPU status write and JTAG clear (jdo[25]): the JTAG clear wins.
- avs_read and avs_write both high: treated as a write. No read is issued.
- Reset mid-operation: FSM returns to IDLE. A pending CPU read is abandoned; waitrequest=0 after reset.

Decomposition:
- Shared package nios2_debug_pkg holds:
  - JDO bit-position constants (JDO_ADDR_LSB=17, JDO_RDREQ=34, JDO_CLR=25, JDO_WDATA_LSB=3).
  - Status bit indices.
  - FSM state enum.
- One sub-module: nios2_debug_ocimem_ram, a single-port byte-enabled synchronous RAM, parameterised by ADDR_W.

Test Plan:
- Reset: assert reset_n=0 mid-J_RD -> all outputs 0, FSM IDLE, a following CPU status read returns 0x0.
- JTAG write burst:
  - Stimulus: a with jdo addr=0x10, jdo[34]=0; then three b pulses with data 0xA5A5_0001..0003, each pulse 10 cycles apart.
  - Response: CPU reads words 0x10..0x12 and gets those values; MonAReg reads 0x13.
- JTAG streaming read:
  - Stimulus: preload RAM[0xFF]=0xDEAD_BEEF and RAM[0]=0x1234_5678; a with addr=0xFF, jdo[34]=1; then no_action_a.
  - Response: MonDReg=0xDEAD_BEEF 2 cycles after the first pulse, then 0x1234_5678 (wrap); MonAReg=0x01.
- Contention:
  - Stimulus: CPU read of word 5 in the same cycle as take_action_ocimem_b.
  - Response: waitrequest held 2 extra cycles; CPU receives post-write data.
- Overrun/priority:
  - Stimulus: b pulse during J_WR; a and b pulsed together.
  - Response: status bit2=1; only the address load occurs. Writing 0x4 clears bit2.
- Monitor flags:
  - Stimulus: CPU writes status 0x3; then a with jdo[25]=1 in the same cycle as a CPU write of 0x1.
  - Response: first, monitor_ready=1 and monitor_error=1; then both flags read 0.
